// File: rtl/prog_controller.sv
// Multi-cycle program controller: fetch/decode FSM, PC/IR, and the datapath control strobes.
// Define PROG_CONTROLLER_ILLEGAL_TRAP_EN to trap opcodes 8-15 into Halt and set the sticky Illegal flag.
module prog_controller #(
   parameter int PC_W    = 7,
   parameter int ROM_LAT = 1
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [15:0]     IR_in,
   input  logic            ALU_Zero,
   input  logic            Resume,
   output logic [PC_W-1:0] PC_Out,
   output logic [15:0]     IR_Out,
   output logic [4:0]      State_Out,
   output logic [4:0]      NextState_Out,
   output logic [7:0]      D_addr,
   output logic            D_wr,
   output logic [3:0]      RF_Ra_addr,
   output logic [3:0]      RF_Rb_addr,
   output logic            RF_WenA,
   output logic            RF_WenB,
   output logic [2:0]      ALU_s,
   output logic            Halted,
   output logic            Illegal
);

   localparam logic [4:0] ST_INIT    = 5'd0;
   localparam logic [4:0] ST_FETCH   = 5'd1;
   localparam logic [4:0] ST_DECODE  = 5'd2;
   localparam logic [4:0] ST_NOOP    = 5'd3;
   localparam logic [4:0] ST_LOAD_A  = 5'd4;
   localparam logic [4:0] ST_LOAD_B  = 5'd5;
   localparam logic [4:0] ST_STORE_A = 5'd6;
   localparam logic [4:0] ST_STORE_B = 5'd7;
   localparam logic [4:0] ST_ARITH_A = 5'd8;
   localparam logic [4:0] ST_ARITH_B = 5'd9;
   localparam logic [4:0] ST_HALT    = 5'd10;
   localparam logic [4:0] ST_JUMP    = 5'd11;

   localparam logic [3:0] OP_NOOP  = 4'h0;
   localparam logic [3:0] OP_STORE = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h5;
   localparam logic [3:0] OP_JMP   = 4'h6;
   localparam logic [3:0] OP_JMPZ  = 4'h7;

   localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
   localparam logic [2:0]      STB_MAX = 3'(ROM_LAT);

   logic [4:0]      r_state;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_ir;
   logic [2:0]      r_stable;

   logic [4:0]      w_next_state;
   logic [PC_W-1:0] w_pc_next;
   logic            w_ir_load;
   logic [3:0]      w_opcode;

   assign w_opcode = r_ir[15:12];

`ifdef PROG_CONTROLLER_ILLEGAL_TRAP_EN
   logic r_illegal;
   logic w_set_illegal;
`endif

   // Next state, next PC and IR capture.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      w_next_state = ST_INIT;
      w_pc_next    = r_pc;
      w_ir_load    = 1'b0;
`ifdef PROG_CONTROLLER_ILLEGAL_TRAP_EN
      w_set_illegal = 1'b0;
`endif
      case (r_state)
         ST_INIT: begin
            w_next_state = ST_FETCH;
            w_pc_next    = '0;
         end
         ST_FETCH: begin
            if (r_stable >= STB_MAX) begin
               w_next_state = ST_DECODE;
               w_ir_load    = 1'b1;
            end else begin
               w_next_state = ST_FETCH;
            end
         end
         ST_DECODE: begin
            w_pc_next = r_pc + PC_ONE;
            case (w_opcode)
               OP_NOOP:          w_next_state = ST_NOOP;
               OP_STORE:         w_next_state = ST_STORE_A;
               OP_LOAD:          w_next_state = ST_LOAD_A;
               OP_ADD, OP_SUB:   w_next_state = ST_ARITH_A;
               OP_HALT:          w_next_state = ST_HALT;
               OP_JMP, OP_JMPZ:  w_next_state = ST_JUMP;
               default: begin
`ifdef PROG_CONTROLLER_ILLEGAL_TRAP_EN
                  w_next_state  = ST_HALT;
                  w_set_illegal = 1'b1;
`else
                  w_next_state  = ST_NOOP;
`endif
               end
            endcase
         end
         ST_NOOP:    w_next_state = ST_FETCH;
         ST_LOAD_A:  w_next_state = ST_LOAD_B;
         ST_LOAD_B:  w_next_state = ST_FETCH;
         ST_STORE_A: w_next_state = ST_STORE_B;
         ST_STORE_B: w_next_state = ST_FETCH;
         ST_ARITH_A: w_next_state = ST_ARITH_B;
         ST_ARITH_B: w_next_state = ST_FETCH;
         ST_HALT:    w_next_state = Resume ? ST_FETCH : ST_HALT;
         ST_JUMP: begin
            w_next_state = ST_FETCH;
            // The PC was already incremented in Decode; a not-taken branch keeps it.
            if ((w_opcode == OP_JMP) || ((w_opcode == OP_JMPZ) && ALU_Zero))
               w_pc_next = r_ir[PC_W-1:0];
         end
         default:    w_next_state = ST_INIT;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state  <= ST_INIT;
         r_pc     <= '0;
         r_ir     <= '0;
         r_stable <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state <= w_next_state;
         r_pc    <= w_pc_next;
         if (w_ir_load)
            r_ir <= IR_in;
         // The counter measures how long the ROM address has been steady.
         if (w_pc_next != r_pc)
            r_stable <= '0;
         else if (r_stable != STB_MAX)
            r_stable <= r_stable + 3'd1;
      end
   end

`ifdef PROG_CONTROLLER_ILLEGAL_TRAP_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         r_illegal <= 1'b0;
      else if (w_set_illegal)
         r_illegal <= 1'b1;
   end
   assign Illegal = r_illegal;
`else
   assign Illegal = 1'b0;
`endif

   // Datapath strobes decoded from the current state and IR only.
   always_comb begin
      D_addr     = '0;
      D_wr       = 1'b0;
      RF_Ra_addr = '0;
      RF_Rb_addr = '0;
      RF_WenA    = 1'b0;
      RF_WenB    = 1'b0;
      ALU_s      = '0;
      case (r_state)
         ST_LOAD_A: D_addr = r_ir[11:4];
         ST_LOAD_B: begin
            D_addr     = r_ir[11:4];
            RF_Ra_addr = r_ir[3:0];
            RF_WenA    = 1'b1;
         end
         ST_STORE_A: RF_Ra_addr = r_ir[11:8];
         ST_STORE_B: begin
            D_addr = r_ir[7:0];
            D_wr   = 1'b1;
         end
         ST_ARITH_A: begin
            RF_Ra_addr = r_ir[11:8];
            RF_Rb_addr = r_ir[7:4];
         end
         ST_ARITH_B: begin
            RF_Rb_addr = r_ir[3:0];
            RF_WenB    = 1'b1;
         end
         default: ;
      endcase
      if ((r_state == ST_ARITH_A) || (r_state == ST_ARITH_B)) begin
         if (w_opcode == OP_ADD)
            ALU_s = 3'd1;
         else if (w_opcode == OP_SUB)
            ALU_s = 3'd2;
      end
   end

   assign PC_Out        = r_pc;
   assign IR_Out        = r_ir;
   assign State_Out     = r_state;
   assign NextState_Out = w_next_state;
   assign Halted        = (r_state == ST_HALT);

endmodule

// File: tb/tb_prog_controller.sv
// Scoreboard bench for prog_controller (PC_W=4, ROM_LAT=3): per-cycle expected trace records
// are queued by the stimulus and compared by an independent monitor on each falling edge.
module tb_prog_controller;

   localparam logic [4:0] S_INIT = 0, S_FETCH = 1, S_DECODE = 2, S_NOOP = 3, S_LOAD_A = 4,
                          S_LOAD_B = 5, S_STORE_A = 6, S_STORE_B = 7, S_ARITH_A = 8,
                          S_ARITH_B = 9, S_HALT = 10, S_JUMP = 11;

   typedef struct packed {
      logic [4:0]  st;
      logic [3:0]  pc;
      logic [15:0] ir;
      logic [7:0]  d_addr;
      logic        d_wr;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic        wa;
      logic        wb;
      logic [2:0]  alu;
      logic        halted;
      logic        illegal;
   } obs_t;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] IR_in;
   logic        ALU_Zero = 1'b0;
   logic        Resume = 1'b0;
   logic [3:0]  PC_Out;
   logic [15:0] IR_Out;
   logic [4:0]  State_Out, NextState_Out;
   logic [7:0]  D_addr;
   logic        D_wr;
   logic [3:0]  RF_Ra_addr, RF_Rb_addr;
   logic        RF_WenA, RF_WenB;
   logic [2:0]  ALU_s;
   logic        Halted, Illegal;

   logic [15:0] rom [16];
   obs_t        exp_q [$];
   string       lbl_q [$];
   logic        exp_ill = 1'b0;
   int          n_tests = 0;
   int          n_fail  = 0;

   assign IR_in = rom[PC_Out];

   always #5 Clk = ~Clk;

   prog_controller #(.PC_W(4), .ROM_LAT(3)) dut (
      .Clk(Clk), .Reset(Reset), .IR_in(IR_in), .ALU_Zero(ALU_Zero), .Resume(Resume),
      .PC_Out(PC_Out), .IR_Out(IR_Out), .State_Out(State_Out), .NextState_Out(NextState_Out),
      .D_addr(D_addr), .D_wr(D_wr), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
      .RF_WenA(RF_WenA), .RF_WenB(RF_WenB), .ALU_s(ALU_s), .Halted(Halted), .Illegal(Illegal)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push_dp(input string lbl, input logic [4:0] st, input logic [3:0] pc,
                          input logic [15:0] ir, input logic [7:0] da, input logic dw,
                          input logic [3:0] ra, input logic [3:0] rb, input logic wa,
                          input logic wb, input logic [2:0] alu);
      obs_t e;
      e.st = st; e.pc = pc; e.ir = ir; e.d_addr = da; e.d_wr = dw; e.ra = ra; e.rb = rb;
      e.wa = wa; e.wb = wb; e.alu = alu; e.halted = (st == S_HALT); e.illegal = exp_ill;
      exp_q.push_back(e);
      lbl_q.push_back(lbl);
   endtask

   task automatic push(input string lbl, input logic [4:0] st, input logic [3:0] pc,
                       input logic [15:0] ir);
      push_dp(lbl, st, pc, ir, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0);
   endtask

   // Monitor: one trace record per falling edge while expectations are pending.
   initial begin
      obs_t a, e;
      string l;
      forever begin
         @(negedge Clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            a.st = State_Out; a.pc = PC_Out; a.ir = IR_Out; a.d_addr = D_addr; a.d_wr = D_wr;
            a.ra = RF_Ra_addr; a.rb = RF_Rb_addr; a.wa = RF_WenA; a.wb = RF_WenB;
            a.alu = ALU_s; a.halted = Halted; a.illegal = Illegal;
            check(l, 64'(a), 64'(e));
         end
      end
   end

   // Holds reset and loads a fresh ROM image; the caller pushes the trace afterwards.
   task automatic start_test();
      @(posedge Clk); #2;
      Reset = 1'b1; Resume = 1'b0; ALU_Zero = 1'b0; exp_ill = 1'b0;
      foreach (rom[i]) rom[i] = 16'h0000;
   endtask

   task automatic release_reset();
      @(negedge Clk); #2;
      Reset = 1'b0;
   endtask

   task automatic drain(input string lbl);
      int budget = 60;
      do begin
         @(negedge Clk); #1;
         budget--;
      end while (exp_q.size() != 0 && budget > 0);
      if (exp_q.size() != 0) begin
         check({lbl, "_timeout"}, 64'(exp_q.size()), 64'd0);
         exp_q.delete();
         lbl_q.delete();
      end
   endtask

   task automatic resume_pulse();
      Resume = 1'b1;
      @(posedge Clk); #2;
      Resume = 1'b0;
   endtask

   // Reset-held Init cycle, three Fetch cycles at PC 0, then Decode of rom[0].
   task automatic prologue(input string lbl, input logic [15:0] ir0);
      push({lbl, "_init"}, S_INIT, 4'd0, 16'h0000);
      for (int i = 0; i < 3; i++) push({lbl, "_fetch0"}, S_FETCH, 4'd0, 16'h0000);
      push({lbl, "_decode0"}, S_DECODE, 4'd0, ir0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      foreach (rom[i]) rom[i] = 16'h0000;

      // Load: three Fetch cycles, then Load_A/Load_B strobes, then a Halt.
      start_test();
      rom[0] = 16'h2123; rom[1] = 16'h5000;
      prologue("load", 16'h2123);
      push_dp("load_a", S_LOAD_A, 4'd1, 16'h2123, 8'h12, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0);
      push_dp("load_b", S_LOAD_B, 4'd1, 16'h2123, 8'h12, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 3'd0);
      push("load_fetch1", S_FETCH, 4'd1, 16'h2123);
      push("load_fetch1", S_FETCH, 4'd1, 16'h2123);
      push("load_decode1", S_DECODE, 4'd1, 16'h5000);
      push("load_halt", S_HALT, 4'd2, 16'h5000);
      push("load_halt_hold", S_HALT, 4'd2, 16'h5000);
      release_reset();
      drain("load");

      // Store path.
      start_test();
      rom[0] = 16'h1A5C;
      prologue("store", 16'h1A5C);
      push_dp("store_a", S_STORE_A, 4'd1, 16'h1A5C, 8'h00, 1'b0, 4'hA, 4'h0, 1'b0, 1'b0, 3'd0);
      push_dp("store_b", S_STORE_B, 4'd1, 16'h1A5C, 8'h5C, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 3'd0);
      push("store_fetch1", S_FETCH, 4'd1, 16'h1A5C);
      release_reset();
      drain("store");

      // Add, then conditional jump taken.
      start_test();
      rom[0] = 16'h3123; rom[1] = 16'h7005; ALU_Zero = 1'b1;
      prologue("addjz", 16'h3123);
      push_dp("add_a", S_ARITH_A, 4'd1, 16'h3123, 8'h00, 1'b0, 4'h1, 4'h2, 1'b0, 1'b0, 3'd1);
      push_dp("add_b", S_ARITH_B, 4'd1, 16'h3123, 8'h00, 1'b0, 4'h0, 4'h3, 1'b0, 1'b1, 3'd1);
      push("addjz_fetch1", S_FETCH, 4'd1, 16'h3123);
      push("addjz_fetch1", S_FETCH, 4'd1, 16'h3123);
      push("addjz_decode1", S_DECODE, 4'd1, 16'h7005);
      push("jz_state", S_JUMP, 4'd2, 16'h7005);
      push("jz_taken_pc", S_FETCH, 4'd5, 16'h7005);
      release_reset();
      drain("addjz");

      // Subtract, then conditional jump not taken.
      start_test();
      rom[0] = 16'h4567; rom[1] = 16'h7005;
      prologue("subjnz", 16'h4567);
      push_dp("sub_a", S_ARITH_A, 4'd1, 16'h4567, 8'h00, 1'b0, 4'h5, 4'h6, 1'b0, 1'b0, 3'd2);
      push_dp("sub_b", S_ARITH_B, 4'd1, 16'h4567, 8'h00, 1'b0, 4'h0, 4'h7, 1'b0, 1'b1, 3'd2);
      push("subjnz_fetch1", S_FETCH, 4'd1, 16'h4567);
      push("subjnz_fetch1", S_FETCH, 4'd1, 16'h4567);
      push("subjnz_decode1", S_DECODE, 4'd1, 16'h7005);
      push("jnz_state", S_JUMP, 4'd2, 16'h7005);
      push("jnz_fallthru_pc", S_FETCH, 4'd2, 16'h7005);
      release_reset();
      drain("subjnz");

      // Jump to 15, NOOP there, PC wraps to 0 and Fetch waits the full latency again.
      start_test();
      rom[0] = 16'h600F; rom[15] = 16'h0000;
      prologue("wrap", 16'h600F);
      push("wrap_jump", S_JUMP, 4'd1, 16'h600F);
      for (int i = 0; i < 4; i++) push("wrap_fetch15", S_FETCH, 4'd15, 16'h600F);
      push("wrap_decode15", S_DECODE, 4'd15, 16'h0000);
      push("wrap_noop_pc0", S_NOOP, 4'd0, 16'h0000);
      for (int i = 0; i < 3; i++) push("wrap_refetch0", S_FETCH, 4'd0, 16'h0000);
      push("wrap_redecode0", S_DECODE, 4'd0, 16'h600F);
      release_reset();
      drain("wrap");

      // Halt holds PC until Resume.
      start_test();
      rom[0] = 16'h5000; rom[1] = 16'h5000;
      prologue("halt", 16'h5000);
      push("halt_enter", S_HALT, 4'd1, 16'h5000);
      push("halt_hold", S_HALT, 4'd1, 16'h5000);
      release_reset();
      drain("halt");
      push("resume_fetch", S_FETCH, 4'd1, 16'h5000);
      push("resume_fetch", S_FETCH, 4'd1, 16'h5000);
      push("resume_decode", S_DECODE, 4'd1, 16'h5000);
      push("resume_halt2", S_HALT, 4'd2, 16'h5000);
      resume_pulse();
      drain("resume");

      // Undefined opcode 0xA.
      start_test();
      rom[0] = 16'hA000; rom[1] = 16'h5000;
      prologue("illop", 16'hA000);
`ifdef PROG_CONTROLLER_ILLEGAL_TRAP_EN
      exp_ill = 1'b1;
      push("illop_trap", S_HALT, 4'd1, 16'hA000);
      push("illop_hold", S_HALT, 4'd1, 16'hA000);
      release_reset();
      drain("illop");
      push("illop_resume", S_FETCH, 4'd1, 16'hA000);
      push("illop_resume", S_FETCH, 4'd1, 16'hA000);
      push("illop_decode1", S_DECODE, 4'd1, 16'h5000);
      push("illop_sticky", S_HALT, 4'd2, 16'h5000);
      resume_pulse();
      drain("illop_sticky");
`else
      push("illop_noop", S_NOOP, 4'd1, 16'hA000);
      for (int i = 0; i < 3; i++) push("illop_fetch1", S_FETCH, 4'd1, 16'hA000);
      push("illop_decode1", S_DECODE, 4'd1, 16'h5000);
      push("illop_halt", S_HALT, 4'd2, 16'h5000);
      release_reset();
      drain("illop");
`endif

      // Asynchronous reset in the middle of a Fetch at PC 1.
      start_test();
      rom[0] = 16'h0000;
      prologue("areset", 16'h0000);
      push("areset_noop", S_NOOP, 4'd1, 16'h0000);
      push("areset_fetch1", S_FETCH, 4'd1, 16'h0000);
      release_reset();
      drain("areset_pre");
      #2;
      Reset = 1'b1;
      #1;
      check("areset_state_async", 64'(State_Out), 64'(S_INIT));
      check("areset_pc_async", 64'(PC_Out), 64'd0);
      check("areset_ir_async", 64'(IR_Out), 64'd0);
      push("areset_init", S_INIT, 4'd0, 16'h0000);
      release_reset();
      for (int i = 0; i < 3; i++) push("areset_fetch0", S_FETCH, 4'd0, 16'h0000);
      push("areset_decode0", S_DECODE, 4'd0, 16'h0000);
      drain("areset_post");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_controller.md
PROG_CONTROLLER -- requirements
Module: prog_controller

Interface
REQ-001 SHALL provide parameter PC_W, default 7: program counter and instruction address width, legal range 4..12.
REQ-002 SHALL provide parameter ROM_LAT, default 1: cycles PC_Out must be stable before IR_in is valid, legal range 1..4.
REQ-003 Clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 IR_in  in  16  instruction word from the external instruction ROM.
REQ-006 ALU_Zero  in  1  datapath flag: ALU result equals zero.
REQ-007 Resume  in  1  level; leaves Halt.
REQ-008 PC_Out  out  PC_W  program counter; drives the ROM address.
REQ-009 IR_Out  out  16  instruction register.
REQ-010 State_Out / NextState_Out  out  5  current and next state codes.
REQ-011 D_addr  out  8  data memory address.
REQ-012 D_wr  out  1  data memory write enable.
REQ-013 RF_Ra_addr / RF_Rb_addr  out  4  register-file read/write addresses.
REQ-014 RF_WenA / RF_WenB  out  1  register-file write enables for the memory and ALU paths.
REQ-015 ALU_s  out  3  ALU function select.
REQ-016 Halted  out  1  high while in Halt.
REQ-017 Illegal  out  1  sticky undefined-opcode flag (see REQ-036).

Function
REQ-018 States and codes SHALL be: Init=0, Fetch=1, Decode=2, NOOP=3, Load_A=4, Load_B=5, Store_A=6, Store_B=7, Arith_A=8, Arith_B=9, Halt=10, Jump=11; unused codes go to Init.
REQ-019 All datapath outputs SHALL be combinational from the state and IR, and 0 in any state not listed below.
REQ-020 Init: PC cleared; next state Fetch.
REQ-021 A saturating stable counter SHALL clear whenever PC changes and increment every cycle otherwise.
REQ-022 Fetch SHALL stay in Fetch until the stable counter reaches ROM_LAT; it then loads IR from IR_in at that edge and moves to Decode.
REQ-023 Decode SHALL dispatch on IR[15:12]: 0 to NOOP, 1 to Store_A, 2 to Load_A, 3 or 4 to Arith_A, 5 to Halt, 6 or 7 to Jump, 8-15 to NOOP.
REQ-024 Decode SHALL increment PC (modulo 2^PC_W) for every opcode, so PC wraps from all-ones to 0.
REQ-025 Load_A: D_addr=IR[11:4]. Load_B: D_addr=IR[11:4], RF_Ra_addr=IR[3:0], RF_WenA=1; next state Fetch.
REQ-026 Store_A: RF_Ra_addr=IR[11:8]. Store_B: D_addr=IR[7:0], D_wr=1; next state Fetch.
REQ-027 Arith_A: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4]. Arith_B: RF_Rb_addr=IR[3:0], RF_WenB=1.
REQ-028 In both Arith states ALU_s SHALL be 1 for opcode 3 (add) and 2 for opcode 4 (subtract).
REQ-029 Jump: opcode 6 loads PC from IR[PC_W-1:0]; opcode 7 loads it only when ALU_Zero=1, otherwise PC keeps its incremented value; next state Fetch.
REQ-030 Halt: Halted=1; PC and IR held; Resume=1 moves to Fetch at the next edge, otherwise stay in Halt.
REQ-031 Reset SHALL take priority over every simultaneous event, including mid-Fetch, mid-Jump and mid-Halt.

Reset
REQ-032 While Reset=1, State SHALL be Init, PC=0, IR=0, stable counter=0 and Illegal=0, independent of Clk.
REQ-033 After release, the first edge SHALL execute Init, which clears PC again, then enter Fetch.

Configuration
REQ-034 Macro PROG_CONTROLLER_ILLEGAL_TRAP_EN SHALL select the handling of opcodes 8-15.
REQ-035 Macro undefined: opcodes 8-15 behave as NOOP, and Illegal is tied to 0.
REQ-036 Macro defined: Decode sends opcodes 8-15 to Halt and sets Illegal; Illegal clears only on Reset, not on Resume.

Verification
REQ-037 Reset asserted mid-Fetch, then released -> State_Out=0 asynchronously; PC_Out=0; Fetch entered after one edge.
REQ-038 ROM_LAT=3, ROM holds 0x2123 at address 0 -> 3 Fetch cycles; then Load_B drives D_addr=0x12, RF_Ra_addr=3, RF_WenA=1 for one cycle.
REQ-039 Program 0x3123, then 0x7005 with ALU_Zero=1 -> ALU_s=1 in both Arith states; PC_Out=5 after Jump; with ALU_Zero=0 instead, PC_Out=2.
REQ-040 PC_W=4, NOOP at address 15 -> PC_Out wraps 15->0; the next Fetch waits ROM_LAT cycles.
REQ-041 0x5000 then Resume pulse -> Halted=1 and PC held at 1; on Resume, Fetch is entered and PC_Out=1.
REQ-042 Opcode 0xA with macro defined -> Halt, Illegal=1 held through Resume; without macro -> NOOP path, Illegal=0.
